// File: rtl/vector_rev_pkg.sv
// vector_rev_pkg
// Shared defaults and FIFO entry types for the vector_rev_arb slice.
//   VR_W      : default data vector width
//   VR_DEPTH  : default output buffer depth (power of two, >= 2)
//   vr_tag_t  : per-entry side information (source index, bypass flag)
//   vr_entry_t: full entry at the default width (data + tag)
// Optional feature macro: VECTOR_REV_BYPASS_EN adds the bypass flag to the tag.
package vector_rev_pkg;

    localparam int VR_W     = 100;
    localparam int VR_DEPTH = 2;

    typedef struct packed {
`ifdef VECTOR_REV_BYPASS_EN
        logic bypass;
`endif
        logic src;
    } vr_tag_t;

    // The top stores data and tag in separate arrays so that the data width
    // can follow the W parameter; this type documents the default layout.
    typedef struct packed {
        logic [VR_W-1:0] data;
        vr_tag_t         tag;
    } vr_entry_t;

endpackage

// File: rtl/vector_rev_core.sv
// vector_rev_core
// Purely combinational bit reversal: dout[i] = din[W-1-i].
// Ports:
//   din  : input vector, bit 0 = LSB
//   dout : reversed vector
module vector_rev_core #(
    parameter int W = 100
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < W; i++) begin
            dout[i] = din[W-1-i];
        end
    end

endmodule

// File: rtl/vector_rev_arb.sv
// vector_rev_arb
// Two-requester round-robin arbiter feeding a small FIFO of bit-reversed
// vectors. One vector is accepted per cycle at most; the accepted vector is
// reversed by a single shared vector_rev_core and written into the FIFO tail
// together with its source index.
// Ports:
//   clk, areset_n             : clock, asynchronous active-low reset
//   req0_valid/data/ready     : requester 0 handshake and vector
//   req1_valid/data/ready     : requester 1 handshake and vector
//   req0_bypass, req1_bypass  : store vector unreversed (VECTOR_REV_BYPASS_EN only)
//   out_valid/ready/data/src  : FIFO head handshake, data and source index
//   busy                      : FIFO holds at least one entry
// Optional feature macro: VECTOR_REV_BYPASS_EN.
module vector_rev_arb
    import vector_rev_pkg::*;
#(
    parameter int W     = VR_W,
    parameter int DEPTH = VR_DEPTH
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
`ifdef VECTOR_REV_BYPASS_EN
    input  logic         req0_bypass,
    input  logic         req1_bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_src,
    output logic         busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_data [DEPTH];
    vr_tag_t          mem_tag  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             rr_last;

    logic             space;
    logic             grant0;
    logic             grant1;
    logic             push;
    logic             pop;
    logic [W-1:0]     sel_data;
    logic [W-1:0]     rev_data;
    logic [W-1:0]     wr_data;
    vr_tag_t          wr_tag;

    assign out_valid = (count != '0);
    assign busy      = out_valid;
    assign pop       = out_valid && out_ready;

    // A full buffer can still accept when the head leaves in the same cycle.
    assign space = (count < CNT_W'(DEPTH)) || pop;

    // rr_last names the last winner; the other requester wins a tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (areset_n && space) begin
            if (req0_valid && req1_valid) begin
                grant0 = rr_last;
                grant1 = !rr_last;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign push       = grant0 || grant1;

    assign sel_data = grant1 ? req1_data : req0_data;

    vector_rev_core #(
        .W(W)
    ) u_core (
        .din (sel_data),
        .dout(rev_data)
    );

    always_comb begin
        wr_tag     = '0;
        wr_tag.src = grant1;
`ifdef VECTOR_REV_BYPASS_EN
        wr_tag.bypass = grant1 ? req1_bypass : req0_bypass;
        wr_data       = wr_tag.bypass ? sel_data : rev_data;
`else
        wr_data       = rev_data;
`endif
    end

    // Storage is not reset; the head is masked whenever the FIFO is empty so
    // stale contents never reach the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= wr_data;
            mem_tag[wr_ptr]  <= wr_tag;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rr_last <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                rr_last <= grant1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_comb begin
        out_data = '0;
        out_src  = 1'b0;
        if (out_valid) begin
            out_data = mem_data[rd_ptr];
            out_src  = mem_tag[rd_ptr].src;
        end
    end

endmodule
